// File: rtl/m_regfile_dumper_pkg.sv
// Shared constants and state encoding for the register-file dumper.
// Imported by the dumper RTL and its bench.
package m_regfile_dumper_pkg;

    localparam int PKG_DW = 32;
    localparam int PKG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT0 = 3'd2,
        ST_EMIT1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/m_regfile_dumper.sv
// Walks a wrapping register range two words at a time through the async read
// ports, streams value+address over valid/ready and accumulates an XOR checksum.
module m_regfile_dumper
    import m_regfile_dumper_pkg::*;
#(
    parameter int DW = PKG_DW,
    parameter int AW = PKG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first,
    input  logic [AW:0]   count,
    output logic [AW-1:0] ra0,
    output logic [AW-1:0] ra1,
    input  logic [DW-1:0] rd0,
    input  logic [DW-1:0] rd1,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    localparam logic [AW:0]   max_cnt_c = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   one_cnt_c = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] zero_a_c  = {AW{1'b0}};
    localparam logic [AW-1:0] one_a_c   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] two_a_c   = {{(AW-2){1'b0}}, 2'b10};
    localparam logic [DW-1:0] zero_d_c  = {DW{1'b0}};

    state_t        state_r, state_next_s;
    logic [AW-1:0] cur_r, cur_next_s;
    logic [AW:0]   rem_r, rem_next_s;
    logic [DW-1:0] hold0_r, hold1_r, csum_next_s;
    logic          handshake_s;

    assign handshake_s = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, counter and checksum update.
    always_comb begin
        state_next_s = state_r;
        cur_next_s   = cur_r;
        rem_next_s   = rem_r;
        csum_next_s  = checksum;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    csum_next_s = zero_d_c;
                    if (count != {(AW+1){1'b0}}) begin
                        cur_next_s   = first;
                        rem_next_s   = (count > max_cnt_c) ? max_cnt_c : count;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_EMIT0;
            end
            ST_EMIT0: begin
                if (handshake_s) begin
                    csum_next_s  = checksum ^ hold0_r;
                    rem_next_s   = rem_r - one_cnt_c;
                    state_next_s = (rem_r == one_cnt_c) ? ST_DONE : ST_EMIT1;
                end else begin
                    state_next_s = ST_EMIT0;
                end
            end
            ST_EMIT1: begin
                if (handshake_s) begin
                    csum_next_s  = checksum ^ hold1_r;
                    rem_next_s   = rem_r - one_cnt_c;
                    cur_next_s   = cur_r + two_a_c;
                    state_next_s = (rem_r == one_cnt_c) ? ST_DONE : ST_FETCH;
                end else begin
                    state_next_s = ST_EMIT1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered datapath; outputs are loaded from the upcoming state so they
    // line up with it, and the stream word is frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_r     <= zero_a_c;
            rem_r     <= {(AW+1){1'b0}};
            hold0_r   <= zero_d_c;
            hold1_r   <= zero_d_c;
            checksum  <= zero_d_c;
            ra0       <= zero_a_c;
            ra1       <= zero_a_c;
            out_data  <= zero_d_c;
            out_addr  <= zero_a_c;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_r     <= cur_next_s;
            rem_r     <= rem_next_s;
            checksum  <= csum_next_s;
            out_valid <= (state_next_s == ST_EMIT0) || (state_next_s == ST_EMIT1);
            busy      <= (state_next_s == ST_FETCH) || (state_next_s == ST_EMIT0)
                         || (state_next_s == ST_EMIT1);
            done      <= (state_next_s == ST_DONE);
            if (state_next_s == ST_FETCH) begin
                ra0 <= cur_next_s;
                ra1 <= cur_next_s + one_a_c;
            end else begin
                ra0 <= zero_a_c;
                ra1 <= zero_a_c;
            end
            if (state_r == ST_FETCH) begin
                hold0_r <= rd0;
                hold1_r <= rd1;
            end else begin
                hold0_r <= hold0_r;
                hold1_r <= hold1_r;
            end
            case (state_next_s)
                ST_EMIT0: begin
                    out_addr <= cur_next_s;
                    out_data <= (state_r == ST_FETCH) ? rd0 : out_data;
                end
                ST_EMIT1: begin
                    out_addr <= cur_next_s + one_a_c;
                    out_data <= (state_r == ST_EMIT0) ? hold1_r : out_data;
                end
                default: begin
                    out_addr <= zero_a_c;
                    out_data <= zero_d_c;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_regfile_dumper.sv
// Directed bench for m_regfile_dumper: a register-file model feeds the read
// ports and a scoreboard queue holds the expected address/data stream.
module tb_m_regfile_dumper;
    import m_regfile_dumper_pkg::*;

    localparam int DW = PKG_DW;
    localparam int AW = PKG_AW;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [AW-1:0] first;
    logic [AW:0]   count;
    logic [AW-1:0] ra0, ra1, out_addr;
    logic [DW-1:0] rd0, rd1, out_data, checksum;
    logic          out_valid, busy, done;

    logic [DW-1:0] rf [NREGS];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    item_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt, done_cnt, busy_cnt, valid_cnt;
    int first_valid_cyc, last_hs_cyc, done_cyc, start_cyc;
    logic          stalled = 1'b0;
    logic          toggle_ready = 1'b0;
    logic [DW-1:0] st_data;
    logic [AW-1:0] st_addr;

    assign rd0 = (ra0 == '0) ? '0 : rf[ra0];
    assign rd1 = (ra1 == '0) ? '0 : rf[ra1];

    always #5 clk = ~clk;

    m_regfile_dumper dut (
        .clk(clk), .reset(reset), .start(start), .first(first), .count(count),
        .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .checksum(checksum)
    );

    function automatic logic [DW-1:0] rf_val(int a);
        return (a == 0) ? '0 : rf[a];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample the outputs present before the coming edge, then advance one cycle.
    task automatic tick();
        item_t it;
        if (out_valid && stalled) begin
            chk("stall_data", out_data, st_data);
            chk("stall_addr", out_addr, st_addr);
        end
        if (out_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            chk("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk("out_addr", out_addr, it.a);
                chk("out_data", out_data, it.d);
            end
        end
        stalled = out_valid && !out_ready;
        st_data = out_data;
        st_addr = out_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_ready) out_ready = ~out_ready;
    endtask

    task automatic clear_stats();
        hs_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        stalled = 1'b0;
    endtask

    task automatic run_dump(int f, int c, bit tog);
        int            n;
        item_t         it;
        logic [DW-1:0] exp_csum;
        n = (c > NREGS) ? NREGS : c;
        exp_csum = '0;
        for (int i = 0; i < n; i++) begin
            it.a = AW'((f + i) % NREGS);
            it.d = rf_val((f + i) % NREGS);
            exp_csum ^= it.d;
            sb.push_back(it);
        end
        clear_stats();
        out_ready = 1'b1;
        toggle_ready = tog;
        start = 1'b1;
        first = AW'(f);
        count = (AW+1)'(c);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
        chk("done_seen", done_cnt, 1);
        tick();
        tick();
        toggle_ready = 1'b0;
        out_ready = 1'b1;
        chk("done_once", done_cnt, 1);
        chk("hs_count", hs_cnt, n);
        chk("sb_drained", sb.size(), 0);
        chk("checksum", checksum, exp_csum);
        chk("idle_busy", busy, 0);
        if (n > 0) begin
            chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
        end else begin
            chk("done_latency", done_cyc, start_cyc + 1);
            chk("no_valid", valid_cnt, 0);
        end
        if (!tog && n > 0) begin
            chk("first_valid_latency", first_valid_cyc, start_cyc + 2);
            chk("busy_cycles", busy_cnt, 3 * (n / 2) + (((n % 2) != 0) ? 2 : 0));
        end
        sb.delete();
    endtask

    initial begin
        item_t it;
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        first = '0; count = '0;
        clear_stats();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_ra0", ra0, 0);
        chk("rst_ra1", ra1, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);

        rf[14] = 32'd69;
        rf[21] = 32'd42;
        run_dump(14, 8, 1'b0);
        rf[0] = 32'd420;
        run_dump(0, 1, 1'b0);
        chk("r0_checksum_zero", checksum, 0);
        run_dump(30, 4, 1'b0);
        run_dump(7, 5, 1'b1);
        run_dump(9, 0, 1'b0);
        run_dump(5, 40, 1'b0);
        run_dump(31, 3, 1'b0);

        // Abandon a dump while it sits in EMIT1.
        clear_stats();
        it.a = AW'(3);
        it.d = rf_val(3);
        sb.push_back(it);
        out_ready = 1'b0;
        start = 1'b1; first = AW'(3); count = (AW+1)'(6);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_emit0_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("emit1_addr", out_addr, 4);
        chk("emit1_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_checksum", checksum, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_ra0", ra0, 0);
        chk("mid_rst_ra1", ra1, 0);
        tick();
        chk("mid_rst_no_done", done_cnt, 0);
        sb.delete();
        tick();
        run_dump(3, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_regfile_dumper.md
Name: m_regfile_dumper

Overview:
Sequential reader for the 32x32 register file. It walks a contiguous, wrapping range of registers through the two asynchronous read ports, two at a time. It streams each value with its address over a valid/ready output and accumulates an XOR checksum. The block is used for debug dumps and context save. While busy it asserts a freeze so the core holds write-enable low.

Parameters:
DW, 32, data width of register file and output stream
AW, 5, register address width (2**AW registers)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a dump; sampled only in IDLE
first  in  AW  first register address, sampled with start
count  in  AW+1  number of registers to emit (0..32; values above 32 clamp to 32)
ra0  out  AW  read address to register-file port 0
ra1  out  AW  read address to register-file port 1
rd0  in  DW  register-file port 0 data (combinational read of ra0)
rd1  in  DW  register-file port 1 data (combinational read of ra1)
out_data  out  DW  streamed register value
out_addr  out  AW  address of out_data
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
busy  out  1  high in FETCH/EMIT0/EMIT1; core must not write the register file
done  out  1  one-cycle pulse when the dump completes
checksum  out  DW  XOR of all words emitted by the last dump

Behaviour:
- Reset (synchronous, active-high) dominates everything: state=IDLE. ra0, ra1, out_data, out_addr, out_valid, busy, done, checksum, cur, remaining and holding registers all go to 0. Reset mid-dump abandons the dump with no done pulse.
- State machine: IDLE, FETCH, EMIT0, EMIT1, DONE.
- IDLE: ra0=ra1=0, out_valid=0.
  - start=1, count!=0: latch cur=first, remaining=min(count,32), clear checksum, go to FETCH.
  - start=1, count==0: clear checksum, go directly to DONE.
  - start=0: stay in IDLE.
- FETCH (1 cycle): ra0=cur, ra1=cur+1 (mod 32). hold0<=rd0 and hold1<=rd1 are captured on the clock edge. Next state is EMIT0.
- EMIT0: out_valid=1, out_data=hold0, out_addr=cur.
  - On out_valid&&out_ready: checksum^=hold0, remaining-=1. Go to DONE if remaining was 1, else EMIT1.
- EMIT1: out_valid=1, out_data=hold1, out_addr=cur+1.
  - On handshake: checksum^=hold1, remaining-=1, cur+=2 (mod 32). Go to DONE if remaining was 1, else FETCH.
- out_data and out_addr hold stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake.
- DONE (1 cycle): done=1, busy=0, out_valid=0, then IDLE. checksum holds until the next accepted start.
- start is ignored outside IDLE, including in the DONE cycle.
- Addresses wrap modulo 32. Example: first=31, count=3 emits 31, 0, 1. Register 0 reads as 0 from the file and is emitted as 0.
- Odd count: the second word of the final pair is fetched but not emitted.
- Throughput with out_ready held high: 3 cycles per pair.
- Latency from start to first out_valid: 2 cycles.

Decomposition:
- Shared package: DW/AW constants, state encoding (IDLE=0, FETCH=1, EMIT0=2, EMIT1=3, DONE=4), register count constant 32.
- No sub-module needed. Optionally m_dump_ctr is a separate sub-module holding the cur/remaining counter pair with its wrap and clamp logic.

Test Plan:
- Preload r14=69 and r21=42. Dump first=14, count=8, out_ready=1 → addrs 14..21 in order; 69 at addr 14, 42 at addr 21; done 1 cycle after the last handshake; checksum = 69^42^(others).
- first=0, count=1 after writing 420 to r0 → single word 0 at addr 0, checksum=0, no EMIT1 entered.
- first=30, count=4 → addrs 30, 31, 0, 1 (wrap); busy high throughout; done pulses exactly once.
- out_ready toggled 0/1 every other cycle, count=5 → out_data/out_addr stable while stalled, exactly 5 handshakes, correct order.
- count=0 → done pulse 1 cycle after start, out_valid never asserted, checksum=0. count=40 → exactly 32 words emitted.
- Reset asserted during EMIT1 → next cycle all outputs 0, state IDLE, no done pulse. A start 2 cycles later yields a full, correct dump.
